// File: rtl/k423_pipe_stage.sv
// ============================================================================
// k423_pipe_stage : parametrised valid/ready pipeline register with optional
//                   2-entry skid buffer, pcu clear/stall.   rev 1.0
// ============================================================================
`default_nettype none

module k423_pipe_stage #(
  parameter int DATA_W     = 64,
  parameter int SKID_EN    = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              stall_i,
  input  logic              up_vld_i,
  output logic              up_rdy_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_vld_o,
  input  logic              dn_rdy_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
);

  // State code doubles as the occupancy count.
  localparam logic [1:0] C_EMPTY = 2'd0;
  localparam logic [1:0] C_BUSY  = 2'd1;
  localparam logic [1:0] C_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic w_main_vld;
  logic w_up_rdy;
  logic w_up_fire;
  logic w_dn_fire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= C_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (clear_i) begin
      state_d = C_EMPTY;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        C_EMPTY: begin
          if (w_up_fire) begin
            state_d     = C_BUSY;
            main_data_d = up_data_i;
          end
        end
        C_BUSY: begin
          if (w_up_fire && w_dn_fire) begin
            main_data_d = up_data_i;
          end else if (w_up_fire && (SKID_EN != 0)) begin
            state_d     = C_FULL;
            skid_data_d = up_data_i;
          end else if (w_dn_fire) begin
            // Payload stays put; only the valid drops.
            state_d = C_EMPTY;
          end
        end
        C_FULL: begin
          if (w_dn_fire) begin
            state_d     = C_BUSY;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = C_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs and handshake terms
  // --------------------------------------------------------------------------
  always_comb begin
    w_main_vld = (state_q != C_EMPTY);
    w_dn_fire  = w_main_vld & dn_rdy_i & ~stall_i & ~clear_i;
    // With the skid enabled, ready never looks at dn_rdy_i.
    if (SKID_EN != 0) begin
      w_up_rdy = ~clear_i & ~stall_i & (state_q != C_FULL);
    end else begin
      w_up_rdy = ~clear_i & ~stall_i & (~w_main_vld | dn_rdy_i);
    end
    w_up_fire = up_vld_i & w_up_rdy;
  end

  assign up_rdy_o  = w_up_rdy;
  assign dn_vld_o  = w_main_vld;
  assign dn_data_o = main_data_q;
  assign occ_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_k423_pipe_stage.sv
// Bench for k423_pipe_stage: table vectors plus scoreboard on a skid/clear-data
// instance, and a hand sequence on a no-skid/hold-data instance.
`default_nettype none

module tb_k423_pipe_stage;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A: SKID_EN=1, CLEAR_DATA=1
  logic        a_clr = 0, a_stl = 0, a_vld = 0, a_rdy = 0;
  logic [63:0] a_data = '0;
  logic        a_up_rdy, a_dn_vld;
  logic [63:0] a_dn_data;
  logic [1:0]  a_occ;

  // Instance B: SKID_EN=0, CLEAR_DATA=0
  logic        b_clr = 0, b_stl = 0, b_vld = 0, b_rdy = 0;
  logic [63:0] b_data = '0;
  logic        b_up_rdy, b_dn_vld;
  logic [63:0] b_dn_data;
  logic [1:0]  b_occ;

  k423_pipe_stage #(.DATA_W(64), .SKID_EN(1), .CLEAR_DATA(1)) u_dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(a_clr), .stall_i(a_stl),
    .up_vld_i(a_vld), .up_rdy_o(a_up_rdy), .up_data_i(a_data),
    .dn_vld_o(a_dn_vld), .dn_rdy_i(a_rdy), .dn_data_o(a_dn_data), .occ_o(a_occ)
  );

  k423_pipe_stage #(.DATA_W(64), .SKID_EN(0), .CLEAR_DATA(0)) u_dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(b_clr), .stall_i(b_stl),
    .up_vld_i(b_vld), .up_rdy_o(b_up_rdy), .up_data_i(b_data),
    .dn_vld_o(b_dn_vld), .dn_rdy_i(b_rdy), .dn_data_o(b_dn_data), .occ_o(b_occ)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of A on the falling edge, then run the scoreboard with
  // the handshake as it stands just before the next rising edge.
  task automatic drive_a(input logic c, input logic s, input logic v,
                         input logic [63:0] d, input logic r);
    @(negedge clk_i);
    a_clr = c; a_stl = s; a_vld = v; a_data = d; a_rdy = r;
    #2;
    if (a_clr) begin
      sb_q.delete();
    end else begin
      if (a_dn_vld && a_rdy && !a_stl) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_underflow: got 0x%0h expected no beat", a_dn_data);
        end else begin
          chk("sb_order", a_dn_data, sb_q.pop_front());
        end
      end
      if (a_vld && a_up_rdy) sb_q.push_back(a_data);
    end
  endtask

  task automatic drive_b(input logic c, input logic v, input logic [63:0] d, input logic r);
    @(negedge clk_i);
    b_clr = c; b_vld = v; b_data = d; b_rdy = r;
    #2;
  endtask

  typedef struct {
    logic        clr, stl, vld;
    logic [63:0] data;
    logic        rdy;
    logic        e_vld;
    logic [63:0] e_data;
    logic [1:0]  e_occ;
    logic        e_urdy;
  } vec_t;

  vec_t vecs[27];

  initial begin
    // Expected values are the outputs seen during the cycle, before its edge.
    // Streaming 0x1..0x8
    vecs[0]  = '{0,0,1,64'h1,1, 0,64'h0,2'd0,1};
    for (int i = 1; i < 8; i++)
      vecs[i] = '{0,0,1,64'(i+1),1, 1,64'(i),2'd1,1};
    vecs[8]  = '{0,0,0,64'h0,1, 1,64'h8,2'd1,1};
    vecs[9]  = '{0,0,0,64'h0,0, 0,64'h8,2'd0,1};
    // Backpressure into the skid
    vecs[10] = '{0,0,1,64'hA,0, 0,64'h8,2'd0,1};
    vecs[11] = '{0,0,1,64'hB,0, 1,64'hA,2'd1,1};
    vecs[12] = '{0,0,1,64'hC,0, 1,64'hA,2'd2,0};
    vecs[13] = '{0,0,0,64'h0,0, 1,64'hA,2'd2,0};
    vecs[14] = '{0,0,0,64'h0,1, 1,64'hA,2'd2,0};
    vecs[15] = '{0,0,0,64'h0,1, 1,64'hB,2'd1,1};
    vecs[16] = '{0,0,0,64'h0,0, 0,64'hB,2'd0,1};
    // Stall holding 0x55
    vecs[17] = '{0,0,1,64'h55,0, 0,64'hB,2'd0,1};
    vecs[18] = '{0,1,1,64'h66,1, 1,64'h55,2'd1,0};
    vecs[19] = '{0,1,1,64'h66,1, 1,64'h55,2'd1,0};
    vecs[20] = '{0,1,1,64'h66,1, 1,64'h55,2'd1,0};
    vecs[21] = '{0,0,0,64'h0,1, 1,64'h55,2'd1,1};
    vecs[22] = '{0,0,0,64'h0,0, 0,64'h55,2'd0,1};
    // Clear in FULL with stall and an incoming beat
    vecs[23] = '{0,0,1,64'h77,0, 0,64'h55,2'd0,1};
    vecs[24] = '{0,0,1,64'h88,0, 1,64'h77,2'd1,1};
    vecs[25] = '{1,1,1,64'h99,1, 1,64'h77,2'd2,0};
    vecs[26] = '{0,0,0,64'h0,0, 0,64'h0,2'd0,1};

    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_a_vld", 64'(a_dn_vld), 64'd0);
    chk("rst_a_data", a_dn_data, 64'd0);
    chk("rst_a_occ", 64'(a_occ), 64'd0);
    chk("rst_b_occ", 64'(b_occ), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive_a(vecs[i].clr, vecs[i].stl, vecs[i].vld, vecs[i].data, vecs[i].rdy);
      chk($sformatf("v%0d_dn_vld", i), 64'(a_dn_vld), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_dn_data", i), a_dn_data, vecs[i].e_data);
      chk($sformatf("v%0d_occ", i), 64'(a_occ), 64'(vecs[i].e_occ));
      chk($sformatf("v%0d_up_rdy", i), 64'(a_up_rdy), 64'(vecs[i].e_urdy));
    end
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    // Reset mid-stream: two beats held in FULL plus one presented upstream
    drive_a(0,0,1,64'hD1,0);
    drive_a(0,0,1,64'hD2,0);
    drive_a(0,0,1,64'hD3,0);
    chk("pre_rst_occ", 64'(a_occ), 64'd2);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    a_vld = 0; a_rdy = 0;
    sb_q.delete();
    #2;
    chk("mid_rst_vld", 64'(a_dn_vld), 64'd0);
    chk("mid_rst_data", a_dn_data, 64'd0);
    chk("mid_rst_occ", 64'(a_occ), 64'd0);
    chk("mid_rst_up_rdy", 64'(a_up_rdy), 64'd1);
    // Single beat after reset: 1-cycle latency
    drive_a(0,0,1,64'hE5,1);
    drive_a(0,0,0,64'h0,1);
    chk("post_rst_data", a_dn_data, 64'hE5);
    chk("post_rst_vld", 64'(a_dn_vld), 64'd1);
    drive_a(0,0,0,64'h0,0);
    chk("post_rst_sb", 64'(sb_q.size()), 64'd0);

    // Instance B: no skid, payload held on clear
    drive_b(0,1,64'h33,0);
    chk("b_empty_rdy", 64'(b_up_rdy), 64'd1);
    drive_b(0,1,64'h44,0);
    chk("b_busy_data", b_dn_data, 64'h33);
    chk("b_busy_occ", 64'(b_occ), 64'd1);
    chk("b_bp_rdy", 64'(b_up_rdy), 64'd0);
    drive_b(0,1,64'h44,1);
    chk("b_pass_rdy", 64'(b_up_rdy), 64'd1);
    drive_b(1,0,64'h0,0);
    chk("b_repl_data", b_dn_data, 64'h44);
    chk("b_repl_vld", 64'(b_dn_vld), 64'd1);
    chk("b_repl_occ", 64'(b_occ), 64'd1);
    chk("b_clr_rdy", 64'(b_up_rdy), 64'd0);
    drive_b(0,0,64'h0,0);
    chk("b_clr_vld", 64'(b_dn_vld), 64'd0);
    chk("b_clr_data", b_dn_data, 64'h44);
    chk("b_clr_occ", 64'(b_occ), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
